// File: rtl/spi_slave_xcvr.sv
// SPI mode-0 slave transceiver: oversampled SCLK/MOSI/SS, MSB-first frames, registered MISO.
// Optional macro SPI_SLV_ECHO_EN: each good frame is reloaded into the holding register.
module spi_slave_xcvr #(
    parameter int FRAME_BITS  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  ss,
    output logic                  miso,
    input  logic [FRAME_BITS-1:0] i_tx_data,
    input  logic                  i_tx_load,
    output logic [FRAME_BITS-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_frame_err,
    output logic                  o_busy
);

    localparam int CNT_W = $clog2(FRAME_BITS + 2);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic                   r_sclk_prev;
    logic                   r_ss_prev;
    logic [FRAME_BITS-1:0]  r_hold;
    logic [FRAME_BITS-1:0]  r_tx;
    logic [FRAME_BITS-1:0]  r_rx;
    logic [FRAME_BITS-1:0]  r_rx_data;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_seen_rise;
    logic                   r_miso;
    logic                   r_rx_valid;
    logic                   r_frame_err;
    logic                   r_busy;

    logic w_sclk;
    logic w_mosi;
    logic w_ss;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_ss_rise;
    logic w_ss_fall;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss        = r_ss_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk & r_sclk_prev;
    assign w_ss_rise   = w_ss & ~r_ss_prev;
    assign w_ss_fall   = ~w_ss & r_ss_prev;

    assign miso        = r_miso;
    assign o_rx_data   = r_rx_data;
    assign o_rx_valid  = r_rx_valid;
    assign o_frame_err = r_frame_err;
    assign o_busy      = r_busy;

    // Chains preset to the bus idle levels so reset release never fakes an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ss_sync   <= '1;
            r_sclk_prev <= 1'b0;
            r_ss_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss};
            r_sclk_prev <= w_sclk;
            r_ss_prev   <= w_ss;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_hold      <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_rx_data   <= '0;
            r_cnt       <= '0;
            r_seen_rise <= 1'b0;
            r_miso      <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            if (i_tx_load) begin
                r_hold <= i_tx_data;
            end
            case (r_state)
                IDLE: begin
                    r_miso <= 1'b0;
                    if (w_ss_fall) begin
                        r_tx        <= r_hold;
                        r_cnt       <= '0;
                        r_seen_rise <= 1'b0;
                        r_miso      <= r_hold[FRAME_BITS-1];
                        r_busy      <= 1'b1;
                        r_state     <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // ss edge takes priority over a coincident sclk edge.
                    if (w_ss_rise) begin
                        r_busy  <= 1'b0;
                        r_miso  <= 1'b0;
                        r_state <= DONE;
                    end else if (w_sclk_rise) begin
                        r_rx        <= {r_rx[FRAME_BITS-2:0], w_mosi};
                        r_seen_rise <= 1'b1;
                        if (r_cnt != CNT_W'(FRAME_BITS + 1)) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else if (w_sclk_fall && r_seen_rise) begin
                        r_tx   <= {r_tx[FRAME_BITS-2:0], 1'b0};
                        r_miso <= r_tx[FRAME_BITS-2];
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    if (r_cnt == CNT_W'(FRAME_BITS)) begin
                        r_rx_data  <= r_rx;
                        r_rx_valid <= 1'b1;
`ifdef SPI_SLV_ECHO_EN
                        if (!i_tx_load) begin
                            r_hold <= r_rx;
                        end
`endif
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_xcvr.sv
// Self-checking bench for spi_slave_xcvr: bench acts as SPI master, model tracks holding/rx words.
// Honours SPI_SLV_ECHO_EN when defined for the build.
module tb_spi_slave_xcvr;

    localparam int FB   = 16;
    localparam int SS_N = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          sclk;
    logic          mosi;
    logic          ss;
    logic          miso;
    logic [FB-1:0] i_tx_data;
    logic          i_tx_load;
    logic [FB-1:0] o_rx_data;
    logic          o_rx_valid;
    logic          o_frame_err;
    logic          o_busy;

    always #5 clk = ~clk;

    spi_slave_xcvr #(
        .FRAME_BITS (FB),
        .SYNC_STAGES(SS_N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sclk       (sclk),
        .mosi       (mosi),
        .ss         (ss),
        .miso       (miso),
        .i_tx_data  (i_tx_data),
        .i_tx_load  (i_tx_load),
        .o_rx_data  (o_rx_data),
        .o_rx_valid (o_rx_valid),
        .o_frame_err(o_frame_err),
        .o_busy     (o_busy)
    );

    int            total   = 0;
    int            bad     = 0;
    int            n_valid = 0;
    int            n_err   = 0;
    logic          quiet   = 1'b0;
    logic [FB-1:0] m_rx    = '0;
    logic [FB-1:0] m_exp   = '0;
    logic [FB-1:0] m_hold  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Per-cycle checks: pulse exclusivity, data on valid, idle outputs between frames.
    always @(negedge clk) begin
        if (o_rx_valid) n_valid++;
        if (o_frame_err) n_err++;
        check("pulse_excl", {31'd0, o_rx_valid & o_frame_err}, 32'd0);
        if (o_rx_valid) check("rx_on_valid", {16'd0, o_rx_data}, {16'd0, m_exp});
        if (quiet) begin
            check("idle_busy", {31'd0, o_busy}, 32'd0);
            check("idle_miso", {31'd0, miso}, 32'd0);
            check("idle_rx", {16'd0, o_rx_data}, {16'd0, m_rx});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [FB-1:0] v);
        tick(1);
        i_tx_data = v;
        i_tx_load = 1'b1;
        tick(1);
        i_tx_load = 1'b0;
        m_hold    = v;
    endtask

    task automatic run_frame(input logic [FB-1:0] mo, input int nbits, input int abort_at,
                             input logic ld_cap, input logic [FB-1:0] ld_val,
                             output logic [31:0] got, output int lat, output int dv,
                             output int de);
        int v0;
        int e0;
        got   = '0;
        lat   = 0;
        v0    = n_valid;
        e0    = n_err;
        quiet = 1'b0;
        tick(1);
        ss = 1'b0;
        if (ld_cap) begin
            // Load lands in the cycle the slave captures the ss fall.
            tick(SS_N);
            i_tx_data = ld_val;
            i_tx_load = 1'b1;
            tick(1);
            i_tx_load = 1'b0;
            tick(3);
        end else begin
            tick(6);
        end
        check("busy_in_frame", {31'd0, o_busy}, 32'd1);
        for (int i = 0; i < nbits; i++) begin
            if (i == abort_at) begin
                reset = 1'b1;
                ss    = 1'b1;
                sclk  = 1'b0;
                m_rx  = '0;
                tick(3);
                check("rst_miso", {31'd0, miso}, 32'd0);
                check("rst_rx", {16'd0, o_rx_data}, 32'd0);
                check("rst_busy", {31'd0, o_busy}, 32'd0);
                reset = 1'b0;
                tick(10);
                dv = n_valid - v0;
                de = n_err - e0;
                return;
            end
            mosi = (i < FB) ? mo[FB-1-i] : 1'($urandom);
            tick(6);
            sclk = 1'b1;
            got  = {got[30:0], miso};
            tick(6);
            sclk = 1'b0;
        end
        tick(6);
        ss = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (lat == 0 && (o_rx_valid || o_frame_err)) lat = k;
        end
        tick(4);
        dv = n_valid - v0;
        de = n_err - e0;
    endtask

    task automatic do_frame(input logic [FB-1:0] mo, input int nbits, input int abort_at,
                            input logic ld_cap, input logic [FB-1:0] ld_val,
                            output logic [31:0] got);
        logic [FB-1:0] tx;
        logic [31:0]   expm;
        int            lat;
        int            dv;
        int            de;
        int            sent;
        logic          good;
        tx   = m_hold;
        good = (nbits == FB) && (abort_at < 0);
        if (good) m_exp = mo;
        run_frame(mo, nbits, abort_at, ld_cap, ld_val, got, lat, dv, de);
        if (ld_cap) m_hold = ld_val;
        sent = (abort_at >= 0 && abort_at < nbits) ? abort_at : nbits;
        expm = '0;
        for (int i = 0; i < sent; i++) expm = {expm[30:0], (i < FB) ? tx[FB-1-i] : 1'b0};
        check("miso_bits", got, expm);
        if (sent != nbits) begin
            m_hold = '0;
            m_rx   = '0;
            check("abort_no_valid", dv, 0);
            check("abort_no_err", de, 0);
        end else begin
            check("valid_count", dv, good ? 1 : 0);
            check("err_count", de, good ? 0 : 1);
            check("end_latency", lat, SS_N + 2);
            if (good) begin
                m_rx = mo;
`ifdef SPI_SLV_ECHO_EN
                m_hold = mo;
`endif
            end
        end
        quiet = 1'b1;
    endtask

    initial begin
        logic [31:0]   got;
        logic [FB-1:0] mo;
        int            v0;
        int            e0;
        int            r;
        int            nb;
        reset     = 1'b1;
        sclk      = 1'b0;
        mosi      = 1'b0;
        ss        = 1'b1;
        i_tx_data = '0;
        i_tx_load = 1'b0;
        tick(3);
        check("reset_miso", {31'd0, miso}, 32'd0);
        check("reset_rx", {16'd0, o_rx_data}, 32'd0);
        check("reset_valid", {31'd0, o_rx_valid}, 32'd0);
        check("reset_err", {31'd0, o_frame_err}, 32'd0);
        check("reset_busy", {31'd0, o_busy}, 32'd0);
        reset = 1'b0;
        tick(5);
        quiet = 1'b1;

        load(16'hA5C3);
        do_frame(16'h1234, 16, -1, 1'b0, '0, got);
        check("t1_miso_literal", got, 32'h0000_A5C3);
        check("t1_rx_literal", {16'd0, o_rx_data}, 32'h0000_1234);

        do_frame(16'h5555, 15, -1, 1'b0, '0, got);
        do_frame(16'hAAAA, 17, -1, 1'b0, '0, got);

        load(16'hFFFF);
        do_frame(16'h0F0F, 16, -1, 1'b1, 16'h00FF, got);
`ifndef SPI_SLV_ECHO_EN
        check("t3_old_word", got, 32'h0000_FFFF);
`endif
        do_frame(16'h7777, 16, -1, 1'b0, '0, got);
`ifndef SPI_SLV_ECHO_EN
        check("t3_new_word", got, 32'h0000_00FF);
`endif

        load(16'hC001);
        do_frame(16'h1111, 16, 8, 1'b0, '0, got);
        do_frame(16'h3FFF, 16, -1, 1'b0, '0, got);
        check("t4_rx_literal", {16'd0, o_rx_data}, 32'h0000_3FFF);

        v0 = n_valid;
        e0 = n_err;
        for (int i = 0; i < 20; i++) begin
            mosi = 1'($urandom);
            tick(5);
            sclk = ~sclk;
        end
        sclk = 1'b0;
        tick(10);
        check("t5_no_valid", n_valid - v0, 0);
        check("t5_no_err", n_err - e0, 0);

        do_frame(16'h0000, 0, -1, 1'b0, '0, got);

`ifdef SPI_SLV_ECHO_EN
        do_frame(16'h0001, 16, -1, 1'b0, '0, got);
        do_frame(16'h0002, 16, -1, 1'b0, '0, got);
        check("t6_echo_literal", got, 32'h0000_0001);
`endif

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 1) load(16'($urandom));
            r  = int'($urandom_range(0, 9));
            nb = (r < 6) ? 16 : (r == 6) ? 15 : (r == 7) ? 17 : (r == 8) ? 0 : 8;
            mo = 16'($urandom);
            do_frame(mo, nb, -1, 1'b0, '0, got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
